// File: rtl/uart_gen_pkg.sv
// Shared types for the oversampling UART receiver: FSM states, parity mode
// and the three-sample majority vote.
package uart_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BRK_WAIT
  } rx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_mode_e;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/prim_fifo_sync.sv
// Single-clock FIFO with flush; a write while full is dropped and flagged
// even when a read happens in the same cycle.
module prim_fifo_sync #(
  parameter int Width = 8,
  parameter int Depth = 16,
  localparam int DepthW = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              wvalid_i,
  input  logic [Width-1:0]  wdata_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [Width-1:0]  rdata_o,
  output logic [DepthW-1:0] depth_o,
  output logic              overflow_o
);

  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [DepthW-1:0] cnt_q;
  logic              full, do_push, do_pop;

  assign full       = (cnt_q == DepthW'(Depth));
  assign rvalid_o   = (cnt_q != '0);
  assign do_push    = wvalid_i & ~full;
  assign do_pop     = rvalid_o & rready_i;
  assign overflow_o = wvalid_i & full;
  assign rdata_o    = mem_q[rd_ptr_q];
  assign depth_o    = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_gen.sv
// UART receiver: NCO-derived oversample tick, majority-voted bits, parity,
// frame and break detection, feeding a receive FIFO with watermark.
//   IDLE: wait for line fall | START: confirm start bit | DATA: shift LSB first
//   PARITY: capture parity bit | STOP1/STOP2: check stop bits
//   BRK_WAIT: line held low after break, wait for it to return high
module uart_rx_gen
  import uart_gen_pkg::*;
#(
  parameter int DataWidth   = 8,
  parameter int OvsRate     = 16,
  parameter int NcoWidth    = 16,
  parameter int RxFifoDepth = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             cfg_en_i,
  input  logic [NcoWidth-1:0]              cfg_nco_i,
  input  logic                             cfg_parity_en_i,
  input  logic                             cfg_parity_odd_i,
  input  logic                             cfg_stop2_i,
  input  logic [$clog2(RxFifoDepth+1)-1:0] cfg_wm_lvl_i,
  input  logic                             fifo_clr_i,
  input  logic                             rx_i,
  output logic [DataWidth-1:0]             rdata_o,
  output logic                             rvalid_o,
  input  logic                             rready_i,
  output logic [$clog2(RxFifoDepth+1)-1:0] fifo_depth_o,
  output logic                             watermark_o,
  output logic                             parity_err_o,
  output logic                             frame_err_o,
  output logic                             break_o,
  output logic                             overflow_o
);

  localparam int CntW = $clog2(OvsRate);
  localparam int IdxW = $clog2(DataWidth);
  localparam logic [CntW-1:0] SmpLo   = CntW'(OvsRate / 2 - 1);
  localparam logic [CntW-1:0] SmpMid  = CntW'(OvsRate / 2);
  localparam logic [CntW-1:0] SmpHi   = CntW'(OvsRate / 2 + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(OvsRate - 1);

  logic rx_s1_q, rx_s2_q, rx_prev_q, rx_fall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end
  assign rx_fall = rx_prev_q & ~rx_s2_q;

  logic [NcoWidth-1:0] acc_q;
  logic [NcoWidth:0]   acc_d;
  logic                tick;

  assign acc_d = {1'b0, acc_q} + {1'b0, cfg_nco_i};
  assign tick  = cfg_en_i & acc_d[NcoWidth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       acc_q <= '0;
    else if (cfg_en_i) acc_q <= acc_d[NcoWidth-1:0];
    else               acc_q <= '0;
  end

  rx_state_e            state_q;
  logic [CntW-1:0]      cnt_q;
  logic [IdxW-1:0]      idx_q;
  logic [1:0]           smp_q;
  logic                 bit_q, par_q;
  logic [DataWidth-1:0] data_q;
  logic                 push_q, perr_q, ferr_q, brk_q, wm_q;
  logic                 bit_now, par_bad, is_break, last_stop, stop_ok;
  parity_mode_e         par_mode;

  assign par_mode  = !cfg_parity_en_i ? PAR_NONE : (cfg_parity_odd_i ? PAR_ODD : PAR_EVEN);
  assign bit_now   = maj3({smp_q, rx_s2_q});
  assign par_bad   = (par_mode != PAR_NONE) && ((^data_q ^ par_q) != (par_mode == PAR_ODD));
  assign is_break  = (state_q == ST_STOP1) && !bit_now && (data_q == '0)
                     && !((par_mode != PAR_NONE) && par_q);
  assign last_stop = (state_q == ST_STOP2) || ((state_q == ST_STOP1) && !cfg_stop2_i);
  // In STOP2, bit_q still holds the STOP1 vote taken at its last sample.
  assign stop_ok   = bit_now && ((state_q == ST_STOP1) || bit_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      smp_q   <= '0;
      bit_q   <= 1'b0;
      par_q   <= 1'b0;
      data_q  <= '0;
      push_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      push_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      brk_q  <= 1'b0;
      if (!cfg_en_i) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rx_fall) begin
              state_q <= ST_START;
              cnt_q   <= '0;
            end
          end
          ST_BRK_WAIT: begin
            if (rx_s2_q) state_q <= ST_IDLE;
          end
          default: begin
            if (tick) begin
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == SmpLo)  smp_q[0] <= rx_s2_q;
              if (cnt_q == SmpMid) smp_q[1] <= rx_s2_q;
              if (cnt_q == SmpHi) begin
                bit_q <= bit_now;
                if (is_break) begin
                  brk_q   <= 1'b1;
                  ferr_q  <= 1'b1;
                  state_q <= ST_BRK_WAIT;
                end else if (last_stop) begin
                  state_q <= ST_IDLE;
                  if (stop_ok) begin
                    push_q <= 1'b1;
                    perr_q <= par_bad;
                  end else begin
                    ferr_q <= 1'b1;
                  end
                end
              end
              if (cnt_q == CntLast) begin
                case (state_q)
                  ST_START: begin
                    idx_q   <= '0;
                    state_q <= bit_q ? ST_IDLE : ST_DATA;
                  end
                  ST_DATA: begin
                    data_q <= {bit_q, data_q[DataWidth-1:1]};
                    idx_q  <= idx_q + 1'b1;
                    if (idx_q == IdxW'(DataWidth - 1))
                      state_q <= cfg_parity_en_i ? ST_PARITY : ST_STOP1;
                  end
                  ST_PARITY: begin
                    par_q   <= bit_q;
                    state_q <= ST_STOP1;
                  end
                  ST_STOP1: state_q <= ST_STOP2;
                  default:  state_q <= state_q;
                endcase
              end
            end
          end
        endcase
      end
    end
  end

  prim_fifo_sync #(
    .Width (DataWidth),
    .Depth (RxFifoDepth)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (fifo_clr_i),
    .wvalid_i   (push_q),
    .wdata_i    (data_q),
    .rvalid_o   (rvalid_o),
    .rready_i   (rready_i),
    .rdata_o    (rdata_o),
    .depth_o    (fifo_depth_o),
    .overflow_o (overflow_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wm_q <= 1'b0;
    else         wm_q <= (cfg_wm_lvl_i != '0) && (fifo_depth_o >= cfg_wm_lvl_i);
  end

  assign watermark_o  = wm_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign break_o      = brk_q;

endmodule

// File: tb/tb_uart_rx_gen.sv
// Scoreboard bench for uart_rx_gen: frames are driven at 32 cycles per bit,
// expected characters are queued and checked by a monitor as they are popped.
module tb_uart_rx_gen;

  logic       clk;
  logic       rst_n;
  logic       cfg_en;
  logic [15:0] cfg_nco;
  logic       cfg_par_en, cfg_par_odd, cfg_stop2;
  logic [4:0] cfg_wm;
  logic       fifo_clr;
  logic       rx;
  logic [7:0] rdata;
  logic       rvalid;
  logic       rready;
  logic [4:0] depth;
  logic       wm, perr, ferr, brk, ovf;

  int checks = 0;
  int errors = 0;
  int n_perr = 0, n_ferr = 0, n_brk = 0, n_ovf = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_v;

  uart_rx_gen dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .cfg_en_i         (cfg_en),
    .cfg_nco_i        (cfg_nco),
    .cfg_parity_en_i  (cfg_par_en),
    .cfg_parity_odd_i (cfg_par_odd),
    .cfg_stop2_i      (cfg_stop2),
    .cfg_wm_lvl_i     (cfg_wm),
    .fifo_clr_i       (fifo_clr),
    .rx_i             (rx),
    .rdata_o          (rdata),
    .rvalid_o         (rvalid),
    .rready_i         (rready),
    .fifo_depth_o     (depth),
    .watermark_o      (wm),
    .parity_err_o     (perr),
    .frame_err_o      (ferr),
    .break_o          (brk),
    .overflow_o       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (perr) n_perr++;
    if (ferr) n_ferr++;
    if (brk)  n_brk++;
    if (ovf)  n_ovf++;
    if (rvalid && rready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %h, expected no character", rdata);
      end else begin
        exp_v = exp_q.pop_front();
        if (rdata !== exp_v) begin
          errors++;
          $display("FAIL pop_data: got %h, expected %h", rdata, exp_v);
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit with_par, input bit par_v,
                            input bit expect_push);
    if (expect_push) exp_q.push_back(d);
    rx = 1'b0;
    cyc(32);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      cyc(32);
    end
    if (with_par) begin
      rx = par_v;
      cyc(32);
    end
    rx = 1'b1;
    cyc(32);
  endtask

  task automatic drain();
    rready = 1'b1;
    for (int k = 0; k < 40 && rvalid; k++) cyc(1);
    rready = 1'b0;
    cyc(2);
  endtask

  initial begin
    rst_n = 1'b0; cfg_en = 1'b1; cfg_nco = 16'h8000;
    cfg_par_en = 1'b0; cfg_par_odd = 1'b0; cfg_stop2 = 1'b0;
    cfg_wm = 5'd0; fifo_clr = 1'b0; rx = 1'b1; rready = 1'b0;
    cyc(5);
    check("reset_rvalid", int'(rvalid), 0);
    check("reset_rdata", int'(rdata), 0);
    check("reset_depth", int'(depth), 0);
    check("reset_pulses", int'({perr, ferr, brk, ovf, wm}), 0);
    rst_n = 1'b1;
    cyc(20);

    // 0xA5, 8N1
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    cyc(8);
    check("a5_rvalid", int'(rvalid), 1);
    check("a5_rdata", int'(rdata), 8'hA5);
    check("a5_depth", int'(depth), 1);
    check("a5_events", n_perr + n_ferr + n_brk + n_ovf, 0);
    drain();
    check("a5_depth_after_pop", int'(depth), 0);

    // 0x03 with even parity but parity bit 1: stored, flagged
    cfg_par_en = 1'b1;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    cyc(8);
    check("par_depth", int'(depth), 1);
    check("par_err_count", n_perr, 1);
    check("par_ferr_count", n_ferr, 0);
    drain();
    cfg_par_en = 1'b0;

    // break: line low for 400 cycles
    rx = 1'b0;
    cyc(400);
    rx = 1'b1;
    cyc(40);
    check("brk_count", n_brk, 1);
    check("brk_ferr_count", n_ferr, 1);
    check("brk_depth", int'(depth), 0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    cyc(8);
    check("post_brk_depth", int'(depth), 1);
    drain();

    // 17 characters without popping: one dropped
    for (int i = 0; i < 17; i++)
      send_frame(8'(8'h10 + 3 * i), 1'b0, 1'b0, i < 16);
    cyc(8);
    check("ovf_depth", int'(depth), 16);
    check("ovf_count", n_ovf, 1);
    drain();
    check("ovf_depth_after_drain", int'(depth), 0);

    // 10-cycle glitch is a false start
    rx = 1'b0;
    cyc(10);
    rx = 1'b1;
    cyc(100);
    check("glitch_depth", int'(depth), 0);
    check("glitch_events", n_perr + n_ferr + n_brk + n_ovf, 4);

    // flush discards stored character
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    cyc(4);
    check("clr_depth_before", int'(depth), 1);
    fifo_clr = 1'b1;
    cyc(1);
    fifo_clr = 1'b0;
    exp_q.delete();
    check("clr_depth_after", int'(depth), 0);
    check("clr_rvalid_after", int'(rvalid), 0);

    // disable during data bit 3 of 0x02, then receive 0x5A
    cfg_wm = 5'd1;
    cyc(2);
    check("wm_empty", int'(wm), 0);
    rx = 1'b0; cyc(32);
    rx = 1'b0; cyc(32);
    rx = 1'b1; cyc(32);
    rx = 1'b0; cyc(32);
    rx = 1'b0; cyc(16);
    cfg_en = 1'b0;
    cyc(10);
    rx = 1'b1;
    cyc(20);
    cfg_en = 1'b1;
    cyc(40);
    check("dis_depth", int'(depth), 0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    cyc(8);
    check("dis_rx_depth", int'(depth), 1);
    check("dis_rx_rdata", int'(rdata), 8'h5A);
    check("dis_watermark", int'(wm), 1);
    drain();
    check("dis_events", n_perr + n_ferr + n_brk + n_ovf, 4);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_gen.md
UART_RX_GEN -- requirements
Module: uart_rx_gen

Interface
REQ-001 SHALL have parameter DataWidth, default 8, data bits per character, legal range 5..9.
REQ-002 SHALL have parameter OvsRate, default 16, oversample ticks per bit, power of two, at least 8.
REQ-003 SHALL have parameter NcoWidth, default 16, baud NCO accumulator width.
REQ-004 SHALL have parameter RxFifoDepth, default 16, receive FIFO entries, at least 2.
REQ-005 SHALL have ports, one per line:
- clk_i, input, 1, the single clock.
- rst_ni, input, 1, asynchronous active-low reset.
- cfg_en_i, input, 1, receiver enable.
- cfg_nco_i, input, NcoWidth, NCO increment.
- cfg_parity_en_i, input, 1, parity bit present.
- cfg_parity_odd_i, input, 1, odd (1) or even (0) parity.
- cfg_stop2_i, input, 1, two stop bits.
- cfg_wm_lvl_i, input, $clog2(RxFifoDepth+1), watermark level.
- fifo_clr_i, input, 1, FIFO flush pulse.
- rx_i, input, 1, asynchronous serial line.
- rdata_o, output, DataWidth, FIFO head.
- rvalid_o, output, 1, FIFO not empty.
- rready_i, input, 1, consumer pop.
- fifo_depth_o, output, $clog2(RxFifoDepth+1), occupancy.
- watermark_o, output, 1, level indication.
- parity_err_o, frame_err_o, break_o, overflow_o, outputs, 1 each, single-cycle event pulses.

Function
REQ-006 SHALL synchronise rx_i through two flops; all logic SHALL use the synchronised value.
REQ-007 SHALL add cfg_nco_i to an NcoWidth-bit accumulator each cycle while cfg_en_i=1; the carry-out is the oversample tick.
REQ-008 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT; state advances only on ticks, except transitions to IDLE.
REQ-009 IDLE->START SHALL occur on a synchronised 1->0 edge; this resets the tick counter to 0.
REQ-010 Each bit value SHALL be the majority of samples at tick counts OvsRate/2-1, OvsRate/2 and OvsRate/2+1; the bit ends at count OvsRate-1.
REQ-011 If the START majority is 1, the FSM SHALL return to IDLE (false start) with no event and no push.
REQ-012 DATA SHALL shift DataWidth bits LSB first.
REQ-013 PARITY SHALL be visited only if cfg_parity_en_i=1; the error condition is XOR(data,parity bit) != cfg_parity_odd_i.
REQ-014 STOP2 SHALL be visited only if cfg_stop2_i=1; a 0 in any stop bit is a frame error.
REQ-015 A break SHALL be detected when data, parity (if present) and STOP1 all sample 0; it pulses break_o and frame_err_o, pushes nothing, and enters BRK_WAIT until the line is 1, then IDLE.
REQ-016 A frame-error character SHALL be discarded.
REQ-017 A parity-error character SHALL be pushed and parity_err_o pulsed.
REQ-018 Push and event pulses SHALL occur the cycle after the final stop-bit sample; rvalid_o SHALL rise the following cycle.
REQ-019 The FIFO pop SHALL occur when rvalid_o && rready_i.
REQ-020 A push when full SHALL drop the character and pulse overflow_o, even if a pop occurs in the same cycle.
REQ-021 fifo_clr_i SHALL empty the FIFO next cycle and win over a same-cycle push or pop.
REQ-022 watermark_o SHALL equal (cfg_wm_lvl_i != 0) && (fifo_depth_o >= cfg_wm_lvl_i), registered.
REQ-023 cfg_en_i=0 SHALL force IDLE, clear the accumulator and tick counter, and discard an in-flight character; FIFO contents SHALL be kept.
REQ-024 Configuration changes mid-character are undefined, except cfg_en_i.

Reset
REQ-025 On reset: FSM IDLE, accumulator 0, synchroniser 1s, FIFO empty, rdata_o 0, all pulses 0, watermark_o 0, fifo_depth_o 0.
REQ-026 A reset mid-character SHALL discard that character with no event.

Structure
REQ-027 Package uart_gen_pkg SHALL hold the FSM state enum and a parity-mode typedef.
REQ-028 The FIFO SHALL be instantiated as prim_fifo_sync; the rest is one module.

Verification (DataWidth=8, OvsRate=16, cfg_nco_i=0x8000, giving a tick every 2 cycles and 32 cycles per bit)
REQ-029 Send 0xA5 8N1 -> rdata_o=0xA5, rvalid_o=1, no events, fifo_depth_o=1.
REQ-030 Send 0x03 with even parity and parity bit 1 -> 0x03 pushed, one parity_err_o pulse.
REQ-031 Hold rx low 400 cycles, then high -> one break_o and one frame_err_o, no push, then IDLE.
REQ-032 Send 17 characters with rready_i=0 -> 16 stored, one overflow_o pulse, first 16 values read back in order.
REQ-033 Send a 10-cycle low glitch -> false start, no push, no event.
REQ-034 Drop cfg_en_i at data bit 3, re-enable, send 0x5A -> only 0x5A received; with cfg_wm_lvl_i=1, watermark_o=1.
